// File: rtl/sram_bus_crossbar_if.sv
// Bundle of the mode handshake, unit-side and memory-side SRAM bus signals of the crossbar.
// Flat vectors are indexed unit*NUM_BUSES+bus; master drives requests and unit buses, slave is the crossbar.
interface sram_bus_crossbar_if #(
    parameter int NUM_UNITS = 3,
    parameter int NUM_BUSES = 5,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MODE_W    = $clog2(NUM_UNITS + 1)
);
    logic [MODE_W-1:0]                       mode_req;
    logic                                    mode_valid;
    logic                                    mode_ready;
    logic                                    switch_done;
    logic [MODE_W-1:0]                       cur_mode;
    logic [NUM_UNITS-1:0]                    unit_idle;
    logic [NUM_UNITS-1:0]                    unit_en;
    logic [NUM_UNITS*NUM_BUSES-1:0]          u_cs;
    logic [NUM_UNITS*NUM_BUSES-1:0]          u_oe;
    logic [NUM_UNITS*NUM_BUSES*ADDR_W-1:0]   u_addr;
    logic [NUM_UNITS*NUM_BUSES*DATA_W-1:0]   u_W_req;
    logic [NUM_UNITS*NUM_BUSES*DATA_W-1:0]   u_W_data;
    logic [NUM_UNITS*NUM_BUSES*DATA_W-1:0]   u_R_data;
    logic [NUM_BUSES-1:0]                    m_cs;
    logic [NUM_BUSES-1:0]                    m_oe;
    logic [NUM_BUSES*ADDR_W-1:0]             m_addr;
    logic [NUM_BUSES*DATA_W-1:0]             m_W_req;
    logic [NUM_BUSES*DATA_W-1:0]             m_W_data;
    logic [NUM_BUSES*DATA_W-1:0]             m_R_data;

    modport master (
        output mode_req, mode_valid, unit_idle,
        output u_cs, u_oe, u_addr, u_W_req, u_W_data, m_R_data,
        input  mode_ready, switch_done, cur_mode, unit_en,
        input  u_R_data, m_cs, m_oe, m_addr, m_W_req, m_W_data
    );

    modport slave (
        input  mode_req, mode_valid, unit_idle,
        input  u_cs, u_oe, u_addr, u_W_req, u_W_data, m_R_data,
        output mode_ready, switch_done, cur_mode, unit_en,
        output u_R_data, m_cs, m_oe, m_addr, m_W_req, m_W_data
    );
endinterface

// File: rtl/sram_bus_crossbar.sv
// Switches NUM_BUSES SRAM buses between NUM_UNITS compute units with a drain phase and an idle gap,
// so ownership never changes under an in-flight access; read data is steered by the previous owner.
module sram_bus_crossbar #(
    parameter int NUM_UNITS  = 3,
    parameter int NUM_BUSES  = 5,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int GAP_CYCLES = 1,
    parameter int MODE_W     = $clog2(NUM_UNITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_bus_crossbar_if.slave   bus
);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [MODE_W-1:0] MAX_MODE = MODE_W'(NUM_UNITS);

    typedef enum logic [1:0] {ACTIVE, DRAIN, GAP} state_t;

    state_t               state_reg;
    logic [MODE_W-1:0]    cur_mode_reg;
    logic [MODE_W-1:0]    target_reg;
    logic [MODE_W-1:0]    rd_owner_reg;
    logic [GAP_W-1:0]     gap_cnt_reg;
    logic [NUM_UNITS-1:0] unit_en_reg;
    logic                 switch_done_reg;

    logic [MODE_W-1:0]    req_mode;
    logic [NUM_UNITS-1:0] owner_sel;
    logic [NUM_UNITS-1:0] target_sel;
    logic                 owner_idle;

    assign req_mode = (bus.mode_req > MAX_MODE) ? '0 : bus.mode_req;
    // unit_en is one-hot of cur_mode outside the gap, so it picks out the old owner's idle flag
    assign owner_idle = (cur_mode_reg == '0) || (|(bus.unit_idle & unit_en_reg));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
            assign owner_sel[gi]  = (cur_mode_reg == MODE_W'(gi + 1));
            assign target_sel[gi] = (target_reg == MODE_W'(gi + 1));
            assign bus.u_R_data[gi*NUM_BUSES*DATA_W +: NUM_BUSES*DATA_W] =
                (rd_owner_reg == MODE_W'(gi + 1)) ? bus.m_R_data : '0;
        end

        for (gi = 0; gi < NUM_BUSES; gi++) begin : g_bus
            logic              cs;
            logic              oe;
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] w_req;
            logic [DATA_W-1:0] w_data;

            always_comb begin
                cs     = 1'b0;
                oe     = 1'b0;
                addr   = '0;
                w_req  = '0;
                w_data = '0;
                for (int u = 0; u < NUM_UNITS; u++) begin
                    if (owner_sel[u]) begin
                        cs     = bus.u_cs[u*NUM_BUSES + gi];
                        oe     = bus.u_oe[u*NUM_BUSES + gi];
                        addr   = bus.u_addr[(u*NUM_BUSES + gi)*ADDR_W +: ADDR_W];
                        w_req  = bus.u_W_req[(u*NUM_BUSES + gi)*DATA_W +: DATA_W];
                        w_data = bus.u_W_data[(u*NUM_BUSES + gi)*DATA_W +: DATA_W];
                    end
                end
            end

            assign bus.m_cs[gi]                      = cs;
            assign bus.m_oe[gi]                      = oe;
            assign bus.m_addr[gi*ADDR_W +: ADDR_W]   = addr;
            assign bus.m_W_req[gi*DATA_W +: DATA_W]  = w_req;
            assign bus.m_W_data[gi*DATA_W +: DATA_W] = w_data;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ACTIVE;
            cur_mode_reg    <= '0;
            target_reg      <= '0;
            rd_owner_reg    <= '0;
            gap_cnt_reg     <= '0;
            unit_en_reg     <= '0;
            switch_done_reg <= 1'b0;
        end else begin
            switch_done_reg <= 1'b0;
            rd_owner_reg    <= cur_mode_reg;
            case (state_reg)
                ACTIVE: begin
                    if (bus.mode_valid) begin
                        if (req_mode == cur_mode_reg) begin
                            switch_done_reg <= 1'b1;
                        end else begin
                            state_reg  <= DRAIN;
                            target_reg <= req_mode;
                        end
                    end
                end
                DRAIN: begin
                    if (owner_idle) begin
                        state_reg    <= GAP;
                        cur_mode_reg <= '0;
                        unit_en_reg  <= '0;
                        gap_cnt_reg  <= GAP_W'(GAP_CYCLES - 1);
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == '0) begin
                        state_reg       <= ACTIVE;
                        cur_mode_reg    <= target_reg;
                        unit_en_reg     <= target_sel;
                        switch_done_reg <= 1'b1;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
                    end
                end
                default: state_reg <= ACTIVE;
            endcase
        end
    end

    assign bus.mode_ready  = (state_reg == ACTIVE);
    assign bus.switch_done = switch_done_reg;
    assign bus.cur_mode    = cur_mode_reg;
    assign bus.unit_en     = unit_en_reg;
endmodule

// File: tb/tb_sram_bus_crossbar.sv
// Bench for sram_bus_crossbar: mode switches with drain/gap timing, bus muxing and read-return scoreboard.
module tb_sram_bus_crossbar;
    localparam int NU  = 3;
    localparam int NB  = 5;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int GAP = 1;
    localparam int MW  = 3;

    typedef struct {
        int            unit;
        int            bus_idx;
        logic [DW-1:0] data;
        int            due;
    } rd_exp_t;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    int      cur_exp = 0;
    rd_exp_t sb[$];

    always #5 clk = ~clk;

    sram_bus_crossbar_if #(.NUM_UNITS(NU), .NUM_BUSES(NB), .ADDR_W(AW), .DATA_W(DW), .MODE_W(MW)) bus ();

    sram_bus_crossbar #(
        .NUM_UNITS(NU), .NUM_BUSES(NB), .ADDR_W(AW), .DATA_W(DW), .GAP_CYCLES(GAP), .MODE_W(MW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] addr, input int b);
        return (addr == 32'h10) ? 32'hDEADBEEF : ((addr ^ 32'hC3C3_0000) + DW'(b));
    endfunction

    function automatic logic [NU-1:0] onehot(input int m);
        logic [NU-1:0] v;
        v = '0;
        if (m > 0) v[m-1] = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory model: read data valid one cycle after cs&oe
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.m_R_data <= '0;
        end else begin
            for (int b = 0; b < NB; b++)
                bus.m_R_data[b*DW +: DW] <= (bus.m_cs[b] & bus.m_oe[b]) ? mem_fn(bus.m_addr[b*AW +: AW], b) : '0;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            check("en_onehot", 64'($countones(bus.unit_en) <= 1), 64'd1);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                rd_exp_t e;
                e = sb.pop_front();
                for (int k = 0; k < NU; k++) begin
                    check($sformatf("rdata_u%0d_b%0d", k, e.bus_idx),
                          bus.u_R_data[(k*NB + e.bus_idx)*DW +: DW],
                          (k == e.unit) ? e.data : '0);
                end
                $display("read: unit %0d bus %0d expected %h", e.unit, e.bus_idx, e.data);
            end
        end
    end

    task automatic clear_units();
        bus.u_cs = '0; bus.u_oe = '0; bus.u_addr = '0; bus.u_W_req = '0; bus.u_W_data = '0;
    endtask

    task automatic rand_units();
        for (int i = 0; i < NU*NB; i++) begin
            bus.u_cs[i] = 1'($urandom_range(0, 1));
            bus.u_oe[i] = 1'($urandom_range(0, 1));
            bus.u_addr[i*AW +: AW]   = $urandom;
            bus.u_W_req[i*DW +: DW]  = $urandom;
            bus.u_W_data[i*DW +: DW] = $urandom;
        end
    endtask

    task automatic check_mux(input int owner);
        #1;
        for (int b = 0; b < NB; b++) begin
            int i;
            i = (owner - 1)*NB + b;
            check("m_cs",     bus.m_cs[b],                      (owner == 0) ? 1'b0 : bus.u_cs[i]);
            check("m_oe",     bus.m_oe[b],                      (owner == 0) ? 1'b0 : bus.u_oe[i]);
            check("m_addr",   bus.m_addr[b*AW +: AW],           (owner == 0) ? '0 : bus.u_addr[i*AW +: AW]);
            check("m_W_req",  bus.m_W_req[b*DW +: DW],          (owner == 0) ? '0 : bus.u_W_req[i*DW +: DW]);
            check("m_W_data", bus.m_W_data[b*DW +: DW],         (owner == 0) ? '0 : bus.u_W_data[i*DW +: DW]);
        end
        $display("mux: owner %0d buses checked", owner);
    endtask

    task automatic do_read(input int u, input int b, input logic [AW-1:0] addr);
        rd_exp_t e;
        bit owned;
        owned = (cur_exp == u + 1);
        clear_units();
        bus.u_cs[u*NB + b] = 1'b1;
        bus.u_oe[u*NB + b] = 1'b1;
        bus.u_addr[(u*NB + b)*AW +: AW] = addr;
        e.unit = owned ? u : -1;
        e.bus_idx = b;
        e.data = owned ? mem_fn(addr, b) : '0;
        e.due = cyc + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        clear_units();
        @(posedge clk); #1;
    endtask

    task automatic do_switch(input logic [MW-1:0] req, input int exp_mode, input int busy, input bit rd_last);
        int old;
        old = cur_exp;
        check("ready_pre", bus.mode_ready, 1'b1);
        bus.mode_req = req;
        bus.mode_valid = 1'b1;
        if (busy > 0 && old != 0) bus.unit_idle[old-1] = 1'b0;
        @(posedge clk); #1;
        bus.mode_valid = 1'b0;
        if (exp_mode == old) begin
            @(negedge clk);
            check("same_done",  bus.switch_done, 1'b1);
            check("same_mode",  bus.cur_mode, 64'(old));
            check("same_ready", bus.mode_ready, 1'b1);
            $display("switch: same mode %0d acknowledged", old);
            @(posedge clk); #1;
            return;
        end
        for (int i = 0; i < busy; i++) begin
            @(negedge clk);
            check("busy_mode",  bus.cur_mode, 64'(old));
            check("busy_ready", bus.mode_ready, 1'b0);
            check("busy_en",    bus.unit_en, onehot(old));
            @(posedge clk); #1;
        end
        bus.unit_idle = '1;
        if (rd_last) begin
            rd_exp_t e;
            clear_units();
            bus.u_cs[(old-1)*NB] = 1'b1;
            bus.u_oe[(old-1)*NB] = 1'b1;
            bus.u_addr[(old-1)*NB*AW +: AW] = 32'h10;
            e.unit = old - 1; e.bus_idx = 0; e.data = 32'hDEADBEEF; e.due = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        check("drain_mode",  bus.cur_mode, 64'(old));
        check("drain_ready", bus.mode_ready, 1'b0);
        if (rd_last) check("drain_addr", bus.m_addr[AW-1:0], 32'h10);
        @(posedge clk); #1;
        clear_units();
        for (int i = 0; i < GAP; i++) begin
            @(negedge clk);
            check("gap_mode",  bus.cur_mode, 64'd0);
            check("gap_en",    bus.unit_en, 64'd0);
            check("gap_cs",    bus.m_cs, 64'd0);
            check("gap_ready", bus.mode_ready, 1'b0);
            check("gap_done",  bus.switch_done, 1'b0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("sw_done",  bus.switch_done, 1'b1);
        check("sw_mode",  bus.cur_mode, 64'(exp_mode));
        check("sw_en",    bus.unit_en, onehot(exp_mode));
        check("sw_ready", bus.mode_ready, 1'b1);
        $display("switch: %0d -> %0d (req %0d, busy %0d)", old, exp_mode, req, busy);
        cur_exp = exp_mode;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not end, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bus.mode_req = '0;
        bus.mode_valid = 1'b0;
        bus.unit_idle = '1;
        clear_units();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mode",  bus.cur_mode, 64'd0);
        check("rst_en",    bus.unit_en, 64'd0);
        check("rst_ready", bus.mode_ready, 1'b1);
        check("rst_done",  bus.switch_done, 1'b0);
        check("rst_m_cs",  bus.m_cs, 64'd0);
        check("rst_rdata", 64'(|bus.u_R_data), 64'd0);
        $display("reset: state checked");
        @(posedge clk); #1;
        rst = 1'b0;

        rand_units(); check_mux(0); clear_units();
        do_switch(3'd1, 1, 0, 1'b0);
        rand_units(); check_mux(1); clear_units();
        @(posedge clk); #1;
        do_read(0, 2, 32'h1234);
        do_read(1, 1, 32'h55);

        do_switch(3'd2, 2, 4, 1'b1);
        do_read(1, 3, 32'h10);

        rand_units(); check_mux(2);
        do_switch(3'd2, 2, 0, 1'b0);
        check_mux(2);
        clear_units();

        do_switch(3'd7, 0, 0, 1'b0);
        rand_units(); check_mux(0);
        check("inv_en", bus.unit_en, 64'd0);
        clear_units();

        // Reset in the middle of the gap
        @(posedge clk); #1;
        bus.mode_req = 3'd2;
        bus.mode_valid = 1'b1;
        @(posedge clk); #1;
        bus.mode_valid = 1'b0;
        @(posedge clk); #2;
        check("gap_ready_low", bus.mode_ready, 1'b0);
        rst = 1'b1;
        #1;
        check("arst_mode",  bus.cur_mode, 64'd0);
        check("arst_en",    bus.unit_en, 64'd0);
        check("arst_ready", bus.mode_ready, 1'b1);
        $display("reset: asserted during gap");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_mode", bus.cur_mode, 64'd0);
            check("post_rst_done", bus.switch_done, 1'b0);
        end
        @(posedge clk); #1;
        cur_exp = 0;
        do_switch(3'd3, 3, 0, 1'b0);
        rand_units(); check_mux(3); clear_units();
        do_read(2, 4, 32'hABCD);

        repeat (2) @(posedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
